// File: rtl/mil_push_fifo_if.sv
// Push/pop handshake bundle for mil_push_fifo.
//   master : upstream writer / downstream reader side (drives requests and push data)
//   slave  : the FIFO (drives done pulses, read data and fill-level status)
interface mil_push_fifo_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             push_request;
  logic [WIDTH-1:0] push_data;
  logic             push_done;
  logic             pop_request;
  logic [WIDTH-1:0] pop_data;
  logic             pop_done;
  logic [CW-1:0]    used;
  logic             empty;
  logic             full;

  modport master (
    output push_request, push_data, pop_request,
    input  push_done, pop_data, pop_done, used, empty, full
  );

  modport slave (
    input  push_request, push_data, pop_request,
    output push_done, pop_data, pop_done, used, empty, full
  );
endinterface

// File: rtl/mil_push_fifo.sv
// Ring buffer between the MIL escape encoder and the SPI-side reader. Words are
// stored verbatim and in order, so two-word escape sequences stay intact.
// Ports:
//   clk   - single rising-edge clock
//   rst   - synchronous reset, active-low
//   clear - synchronous flush, active-high (pop_data is kept)
//   bus   - slave side of mil_push_fifo_if: push/pop request/done handshakes,
//           registered pop_data, fill level used/empty/full
module mil_push_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64
) (
  input logic           clk,
  input logic           rst,
  input logic           clear,
  mil_push_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] WIdle  = 2'd0;
  localparam logic [1:0] WStall = 2'd1;
  localparam logic [1:0] WDone  = 2'd2;

  localparam logic [1:0] RIdle  = 2'd0;
  localparam logic [1:0] RWait  = 2'd1;
  localparam logic [1:0] RDone  = 2'd2;

  logic [1:0]       wr_state_q, wr_state_d;
  logic [1:0]       rd_state_q, rd_state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    used_q, used_d;
  logic [WIDTH-1:0] wbuf_q, wbuf_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wr_en, rd_en;
  logic [WIDTH-1:0] wr_word;
  logic             full, empty;

  // Status comes from the registered count only, so a stalled side proceeds one
  // cycle after the other side frees a slot / lands a word, and read and write
  // can never address the same slot in the same cycle.
  assign full  = (used_q == CW'(DEPTH));
  assign empty = (used_q == '0);

  // Write side
  always_comb begin
    wr_en      = 1'b0;
    wr_word    = wbuf_q;
    wr_state_d = wr_state_q;
    wbuf_d     = wbuf_q;
    case (wr_state_q)
      WIdle: begin
        if (bus.push_request) begin
          wbuf_d  = bus.push_data;
          wr_word = bus.push_data;
          if (!full) begin
            wr_en      = 1'b1;
            wr_state_d = WDone;
          end else begin
            wr_state_d = WStall;
          end
        end
      end
      WStall: begin
        if (!full) begin
          wr_en      = 1'b1;
          wr_state_d = WDone;
        end
      end
      WDone:   wr_state_d = WIdle;
      default: wr_state_d = WIdle;
    endcase
    if (clear) begin
      wr_en      = 1'b0;
      wr_state_d = WIdle;
    end
  end

  // Read side
  always_comb begin
    rd_en      = 1'b0;
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RIdle: begin
        if (bus.pop_request) begin
          if (!empty) begin
            rd_en      = 1'b1;
            rd_state_d = RDone;
          end else begin
            rd_state_d = RWait;
          end
        end
      end
      RWait: begin
        if (!empty) begin
          rd_en      = 1'b1;
          rd_state_d = RDone;
        end
      end
      RDone:   rd_state_d = RIdle;
      default: rd_state_d = RIdle;
    endcase
    if (clear) begin
      rd_en      = 1'b0;
      rd_state_d = RIdle;
    end
  end

  // Pointers, level and read register
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    used_d     = used_q;
    pop_data_d = pop_data_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      pop_data_d = mem_q[rd_ptr_q];
    end
    if (wr_en && !rd_en) begin
      used_d = used_q + CW'(1);
    end else if (rd_en && !wr_en) begin
      used_d = used_q - CW'(1);
    end
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      used_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_state_q <= WIdle;
      rd_state_q <= RIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      used_q     <= '0;
      wbuf_q     <= '0;
      pop_data_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      used_q     <= used_d;
      wbuf_q     <= wbuf_d;
      pop_data_q <= pop_data_d;
    end
  end

  // Storage is never cleared; only the pointers define valid content.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  assign bus.push_done = (wr_state_q == WDone);
  assign bus.pop_done  = (rd_state_q == RDone);
  assign bus.pop_data  = pop_data_q;
  assign bus.used      = used_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
endmodule

// File: tb/tb_mil_push_fifo.sv
module tb_mil_push_fifo;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  logic clear;

  mil_push_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mil_push_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] q[$];          // reference model: words committed and not yet popped
  logic [15:0] last_pop = '0; // last word the model says was popped

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.push_request = 1'b1;
    bus.push_data = 16'h9999;
    repeat (3) tick();
    n_cmp++; if (bus.push_done !== 1'b0) begin n_fail++;
      $display("FAIL reset_push_done got %b want 0", bus.push_done); end
    n_cmp++; if (bus.used !== 3'd0) begin n_fail++;
      $display("FAIL reset_used got %0d want 0", bus.used); end
    n_cmp++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++;
      $display("FAIL reset_flags got empty=%b full=%b want 1/0", bus.empty, bus.full); end
    n_cmp++; if (bus.pop_data !== 16'h0000) begin n_fail++;
      $display("FAIL reset_pop_data got %h want 0000", bus.pop_data); end
    rst = 1'b1;
    bus.push_request = 1'b0;
    tick();
    bus.push_request = 1'b1;
    bus.push_data = 16'h1234;
    tick();
    bus.push_request = 1'b0;
    q.push_back(16'h1234);
    n_cmp++; if (bus.push_done !== 1'b1 || bus.used !== 3'd1) begin n_fail++;
      $display("FAIL first_push got done=%b used=%0d want 1/1", bus.push_done, bus.used); end
    tick();
    n_cmp++; if (bus.push_done !== 1'b0) begin n_fail++;
      $display("FAIL done_width got %b want 0", bus.push_done); end
  endtask

  task automatic test_order();
    logic [15:0] w [3];
    w[0] = 16'hFFA1; w[1] = 16'h0821; w[2] = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      bus.push_request = 1'b1;
      bus.push_data = w[i];
      tick();
      bus.push_request = 1'b0;
      q.push_back(w[i]);
      n_cmp++; if (bus.push_done !== 1'b1) begin n_fail++;
        $display("FAIL order_push%0d got done=%b want 1", i, bus.push_done); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] exp;
      exp = q.pop_front();
      bus.pop_request = 1'b1;
      tick();
      bus.pop_request = 1'b0;
      last_pop = exp;
      n_cmp++; if (bus.pop_done !== 1'b1 || bus.pop_data !== exp) begin n_fail++;
        $display("FAIL order_pop%0d got done=%b data=%h want 1/%h",
                 i, bus.pop_done, bus.pop_data, exp); end
      tick();
    end
    n_cmp++; if (bus.empty !== 1'b1) begin n_fail++;
      $display("FAIL order_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      bus.push_request = 1'b1;
      bus.push_data = d;
      tick();
      bus.push_request = 1'b0;
      q.push_back(d);
      tick();
    end
    n_cmp++; if (bus.full !== 1'b1 || bus.used !== 3'd4) begin n_fail++;
      $display("FAIL stall_full got full=%b used=%0d want 1/4", bus.full, bus.used); end
    bus.push_request = 1'b1;
    bus.push_data = 16'hBEEF;
    tick();
    bus.push_request = 1'b0;
    n_cmp++; if (bus.push_done !== 1'b0) begin n_fail++;
      $display("FAIL stall_no_done got %b want 0", bus.push_done); end
    tick();
    n_cmp++; if (bus.push_done !== 1'b0 || bus.full !== 1'b1) begin n_fail++;
      $display("FAIL stall_hold got done=%b full=%b want 0/1", bus.push_done, bus.full); end
    bus.pop_request = 1'b1;
    tick();
    bus.pop_request = 1'b0;
    last_pop = q.pop_front();
    n_cmp++; if (bus.pop_done !== 1'b1 || bus.pop_data !== last_pop ||
                 bus.push_done !== 1'b0) begin n_fail++;
      $display("FAIL stall_pop got pop_done=%b data=%h push_done=%b want 1/%h/0",
               bus.pop_done, bus.pop_data, bus.push_done, last_pop); end
    tick();
    q.push_back(16'hBEEF);
    n_cmp++; if (bus.push_done !== 1'b1 || bus.used !== 3'd4) begin n_fail++;
      $display("FAIL stall_release got done=%b used=%0d want 1/4", bus.push_done, bus.used); end
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      bus.pop_request = 1'b1;
      tick();
      bus.pop_request = 1'b0;
      last_pop = q.pop_front();
      n_cmp++; if (bus.pop_done !== 1'b1 || bus.pop_data !== last_pop) begin n_fail++;
        $display("FAIL stall_drain%0d got done=%b data=%h want 1/%h",
                 i, bus.pop_done, bus.pop_data, last_pop); end
      tick();
    end
    n_cmp++; if (last_pop !== 16'hBEEF || bus.empty !== 1'b1) begin n_fail++;
      $display("FAIL stall_last got last=%h empty=%b want BEEF/1", last_pop, bus.empty); end
  endtask

  task automatic test_empty_wait();
    bus.pop_request = 1'b1;
    tick();
    bus.pop_request = 1'b0;
    n_cmp++; if (bus.pop_done !== 1'b0) begin n_fail++;
      $display("FAIL wait_no_done got %b want 0", bus.pop_done); end
    tick();
    n_cmp++; if (bus.pop_done !== 1'b0) begin n_fail++;
      $display("FAIL wait_hold got %b want 0", bus.pop_done); end
    bus.push_request = 1'b1;
    bus.push_data = 16'h00AA;
    tick();
    bus.push_request = 1'b0;
    n_cmp++; if (bus.push_done !== 1'b1 || bus.pop_done !== 1'b0) begin n_fail++;
      $display("FAIL wait_push got push_done=%b pop_done=%b want 1/0",
               bus.push_done, bus.pop_done); end
    tick();
    last_pop = 16'h00AA;
    n_cmp++; if (bus.pop_done !== 1'b1 || bus.pop_data !== 16'h00AA || bus.used !== 3'd0)
    begin n_fail++;
      $display("FAIL wait_release got done=%b data=%h used=%0d want 1/00aa/0",
               bus.pop_done, bus.pop_data, bus.used); end
    tick();
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 2; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      bus.push_request = 1'b1;
      bus.push_data = d;
      tick();
      bus.push_request = 1'b0;
      q.push_back(d);
      tick();
    end
    for (int i = 0; i < 1 + 3 * DEPTH; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      bus.push_request = 1'b1;
      bus.pop_request = 1'b1;
      bus.push_data = d;
      tick();
      bus.push_request = 1'b0;
      bus.pop_request = 1'b0;
      last_pop = q.pop_front();
      q.push_back(d);
      n_cmp++; if ({bus.push_done, bus.pop_done} !== 2'b11 || bus.pop_data !== last_pop ||
                   bus.used !== 3'd2) begin n_fail++;
        $display("FAIL simul%0d got dones=%b%b data=%h used=%0d want 11/%h/2",
                 i, bus.push_done, bus.pop_done, bus.pop_data, bus.used, last_pop); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      bus.pop_request = 1'b1;
      tick();
      bus.pop_request = 1'b0;
      last_pop = q.pop_front();
      n_cmp++; if (bus.pop_done !== 1'b1 || bus.pop_data !== last_pop) begin n_fail++;
        $display("FAIL simul_drain%0d got done=%b data=%h want 1/%h",
                 i, bus.pop_done, bus.pop_data, last_pop); end
      tick();
    end
  endtask

  // Free-running random traffic: the model commits a word on push_done and
  // retires the oldest word on pop_done; level and flags follow the queue size.
  task automatic test_random();
    bit pb, rb, pj, rj;
    logic [15:0] pend;
    pb = 0; rb = 0; pj = 0; rj = 0; pend = '0;
    for (int i = 0; i < 700; i++) begin
      bit want_push, want_pop;
      if (i >= 500 && !pb && !rb) break;
      if (i < 500) begin
        want_push = ($urandom % 3) != 0;
        want_pop  = ($urandom % 2) == 0;
      end else begin
        // Settle: only issue what unblocks the other outstanding side.
        want_push = rb;
        want_pop  = pb;
      end
      bus.push_request = want_push && !pb && !pj;
      bus.pop_request  = want_pop && !rb && !rj;
      if (bus.push_request) begin
        pend = 16'($urandom);
        bus.push_data = pend;
        pb = 1;
      end
      if (bus.pop_request) rb = 1;
      tick();
      bus.push_request = 1'b0;
      bus.pop_request = 1'b0;
      rj = 0;
      pj = 0;
      if (bus.pop_done === 1'b1) begin
        n_cmp++;
        if (!rb || q.size() == 0) begin n_fail++;
          $display("FAIL rand_spurious_pop cycle %0d got pop_done=1 want 0", i);
        end else begin
          last_pop = q.pop_front();
          if (bus.pop_data !== last_pop) begin n_fail++;
            $display("FAIL rand_pop_data cycle %0d got %h want %h", i, bus.pop_data, last_pop);
          end
        end
        rb = 0; rj = 1;
      end
      if (bus.push_done === 1'b1) begin
        n_cmp++;
        if (!pb) begin n_fail++;
          $display("FAIL rand_spurious_push cycle %0d got push_done=1 want 0", i);
        end else q.push_back(pend);
        pb = 0; pj = 1;
      end
      n_cmp++;
      if (bus.used !== 3'(q.size()) || bus.empty !== (q.size() == 0) ||
          bus.full !== (q.size() == DEPTH)) begin n_fail++;
        $display("FAIL rand_level cycle %0d got used=%0d empty=%b full=%b want used=%0d",
                 i, bus.used, bus.empty, bus.full, q.size());
      end
    end
    n_cmp++; if (pb || rb) begin n_fail++;
      $display("FAIL rand_timeout got pending push=%0d pop=%0d want 0/0", pb, rb); end
    tick();
  endtask

  task automatic test_flush();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    q.delete();
    n_cmp++; if (bus.used !== 3'd0 || bus.empty !== 1'b1 || bus.pop_data !== last_pop)
    begin n_fail++;
      $display("FAIL clear_state got used=%0d empty=%b data=%h want 0/1/%h",
               bus.used, bus.empty, bus.pop_data, last_pop); end
    for (int i = 0; i < DEPTH; i++) begin
      bus.push_request = 1'b1;
      bus.push_data = 16'($urandom);
      tick();
      bus.push_request = 1'b0;
      tick();
    end
    bus.push_request = 1'b1;
    bus.push_data = 16'hCAFE;
    tick();
    bus.push_request = 1'b0;
    n_cmp++; if (bus.push_done !== 1'b0 || bus.full !== 1'b1) begin n_fail++;
      $display("FAIL flush_stall got done=%b full=%b want 0/1", bus.push_done, bus.full); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (bus.used !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
                 bus.push_done !== 1'b0) begin n_fail++;
      $display("FAIL flush_state got used=%0d empty=%b full=%b done=%b want 0/1/0/0",
               bus.used, bus.empty, bus.full, bus.push_done); end
    tick();
    n_cmp++; if (bus.push_done !== 1'b0 || bus.used !== 3'd0) begin n_fail++;
      $display("FAIL flush_abandon got done=%b used=%0d want 0/0", bus.push_done, bus.used); end
    bus.push_request = 1'b1;
    bus.push_data = 16'h7777;
    tick();
    bus.push_request = 1'b0;
    n_cmp++; if (bus.push_done !== 1'b1 || bus.used !== 3'd1) begin n_fail++;
      $display("FAIL flush_push got done=%b used=%0d want 1/1", bus.push_done, bus.used); end
    tick();
    bus.pop_request = 1'b1;
    tick();
    bus.pop_request = 1'b0;
    n_cmp++; if (bus.pop_done !== 1'b1 || bus.pop_data !== 16'h7777) begin n_fail++;
      $display("FAIL flush_pop got done=%b data=%h want 1/7777", bus.pop_done, bus.pop_data); end
    tick();
    n_cmp++; if (bus.empty !== 1'b1) begin n_fail++;
      $display("FAIL flush_empty got %b want 1", bus.empty); end
  endtask

  initial begin
    rst = 1'b0;
    clear = 1'b0;
    bus.push_request = 1'b0;
    bus.push_data = '0;
    bus.pop_request = 1'b0;
    #2;
    test_reset();
    test_order();
    test_full_stall();
    test_empty_wait();
    test_simultaneous();
    test_random();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
